// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM and the
// Funct->ALUControl decoder reused by the single-cycle core.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BEQ,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type Funct -> ALUControl decode; unknown functs fall back to AND.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [5:0]            funct_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_CTRL_W'(ALU_AND);
        case (funct_i)
            FN_ADD:  alu_ctrl_o = ALU_CTRL_W'(ALU_ADD);
            FN_SUB:  alu_ctrl_o = ALU_CTRL_W'(ALU_SUB);
            FN_AND:  alu_ctrl_o = ALU_CTRL_W'(ALU_AND);
            FN_OR:   alu_ctrl_o = ALU_CTRL_W'(ALU_OR);
            FN_SLT:  alu_ctrl_o = ALU_CTRL_W'(ALU_SLT);
            default: alu_ctrl_o = ALU_CTRL_W'(ALU_AND);
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait-state handshake and timeout fault.
// Define ILLEGAL_OP_TRAP_EN to send unknown opcodes to FAULT instead of treating them as NOPs.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            Op,
    input  logic [5:0]            Funct,
    input  logic                  Zero,
    input  logic                  mem_ready,
    output logic                  IorD,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic                  PCEn,
    output logic [1:0]            PCSrc,
    output logic                  ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  RegDst,
    output logic                  MemtoReg,
    output logic                  RegWrite,
    output logic                  instr_done,
    output logic                  bus_err
);

    localparam bit         TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [7:0] WAIT_LAST  = TIMEOUT_EN ? 8'(MEM_TIMEOUT - 1) : 8'd0;

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  bus_err_q, bus_err_d;
    logic [ALU_CTRL_W-1:0] funct_alu;
    logic                  mem_state, stall, timeout;
    logic                  pc_write, branch;

    mips_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .funct_i    (Funct),
        .alu_ctrl_o (funct_alu)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign stall     = mem_state && !mem_ready;
    // The stall that would bring the count up to MEM_TIMEOUT is the one that faults.
    assign timeout   = TIMEOUT_EN && stall && (wait_q == WAIT_LAST);

    always_comb begin
        wait_d = '0;
        if (stall && !timeout) begin
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        end
    end

    assign bus_err_d = bus_err_q || (state_d == S_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = '0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB    = 2'b01;
                    ALUControl = ALU_CTRL_W'(ALU_ADD);
                    if (mem_ready) begin
                        IRWrite  = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    ALUControl = ALU_CTRL_W'(ALU_ADD);
                    case (Op)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BEQ;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                            state_d = S_FAULT;
`else
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
`endif
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_CTRL_W'(ALU_ADD);
                    state_d    = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    IorD = 1'b1;
                    if (mem_ready)    state_d = S_MEMWB;
                    else if (timeout) state_d = S_FAULT;
                end
                S_MEMWB: begin
                    MemtoReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_EXECUTE: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = funct_alu;
                    state_d    = S_ALUWB;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_BEQ: begin
                    ALUSrcA    = 1'b1;
                    ALUControl = ALU_CTRL_W'(ALU_SUB);
                    PCSrc      = 2'b01;
                    branch     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_ADDIEX: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = 2'b10;
                    ALUControl = ALU_CTRL_W'(ALU_ADD);
                    state_d    = S_ADDIWB;
                end
                S_ADDIWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_JUMP: begin
                    PCSrc      = 2'b10;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign PCEn    = pc_write || (branch && Zero);
    assign bus_err = bus_err_q && !reset;

endmodule
